mant_div_iter: RTL

Iterative restoring mantissa divider for the single-precision FPU divide path. It accepts two normalized 24-bit mantissas (hidden bit included) and produces one quotient bit per clock using a restoring shift/subtract step. It returns a QW-bit quotient plus a sticky bit to the downstream normalize/round stage through a start/busy/done handshake. It sits between operand unpack (upstream) and normalize/round (downstream).

---
 rtl/mant_div_iter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mant_div_iter.sv
// mant_div_iter: iterative restoring mantissa divider, one quotient bit per clock.
// Optional MANT_DIV_EARLY_TERM_EN stops as soon as the partial remainder reaches zero.
module mant_div_iter #(
    parameter int MW = 24,
    parameter int QW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [MW-1:0] mant_a,
    input  logic [MW-1:0] mant_b,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quot,
    output logic          sticky,
    output logic          div_zero
);
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [MW:0]   rem_q, rem_d, diff, next_rem;
    logic [MW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] quot_q, quot_d, q_shift;
    logic          sticky_q, sticky_d, dz_q, dz_d, ge, last;

    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign quot     = quot_q;
    assign sticky   = sticky_q;
    assign div_zero = dz_q;

    always_comb begin
        ge       = rem_q >= {1'b0, div_q};
        diff     = rem_q - {1'b0, div_q};
        // rem < 2*divisor keeps the shifted-out top bit zero
        next_rem = ge ? diff << 1 : rem_q << 1;
        q_shift  = {quot_q[QW-2:0], ge};
        last     = cnt_q == CW'(QW - 1);
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                div_d    = mant_b;
                cnt_d    = '0;
                sticky_d = 1'b0;
                dz_d     = mant_b == '0;
                rem_d    = mant_b == '0 ? '0 : {1'b0, mant_a};
                quot_d   = mant_b == '0 ? '1 : '0;
            end
            // a divide-by-zero spends one idle RUN cycle so done lands one cycle after accept
            RUN: if (dz_q) begin
                state_d = DONE;
            end else begin
                rem_d  = next_rem;
                quot_d = q_shift;
                cnt_d  = cnt_q + CW'(1);
`ifdef MANT_DIV_EARLY_TERM_EN
                if (last || next_rem == '0) begin
                    state_d  = DONE;
                    sticky_d = |next_rem;
                    quot_d   = q_shift << (CW'(QW - 1) - cnt_q);
                end
`else
                if (last) begin
                    state_d  = DONE;
                    sticky_d = |next_rem;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end
endmodule
